multicycle_control_fsm: RTL and testbench

//  Control state machine for the multi-cycle RV32I core: sequences one shared ALU, one unified

---
 rtl/multicycle_control_fsm_pkg.sv | 50 +++++
 rtl/multicycle_control_fsm_if.sv | 37 +++
 rtl/mcfsm_output_decode.sv | 95 +++++++++
 rtl/multicycle_control_fsm.sv | 88 ++++++++
 tb/tb_multicycle_control_fsm.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
// Holds the RV32I major opcodes, the 3-bit state encoding, ALU operand/op selector codes and
// the packed control word produced by the output decoder.
package multicycle_control_fsm_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // ALU operand B selector
  localparam logic [1:0] SrcBReg  = 2'd0;
  localparam logic [1:0] SrcBFour = 2'd1;
  localparam logic [1:0] SrcBImm  = 2'd2;

  // ALU operation class
  localparam logic [1:0] AluAdd    = 2'd0;
  localparam logic [1:0] AluBranch = 2'd1;
  localparam logic [1:0] AluFunct  = 2'd2;

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StEx   = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StBrNt = 3'd5,
    StHalt = 3'd6
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the control FSM and the datapath.
// master: the control FSM (drives control strobes, halt flag and counters).
// slave:  the datapath (drives opcode, branch condition, halt request and memory ready).
interface multicycle_control_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             alu_bcond;
  logic             ecall_halt;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             is_halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, alu_bcond, ecall_halt, mem_ready,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b,
           alu_op, reg_write, mem_to_reg, is_halted, cycle_count, instret
  );

  modport slave (
    output opcode, alu_bcond, ecall_halt, mem_ready,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b,
           alu_op, reg_write, mem_to_reg, is_halted, cycle_count, instret
  );
endinterface

// File: rtl/mcfsm_output_decode.sv
// Moore output decode of the control FSM state (plus mem_ready / alu_bcond where a state
// completes early). Ports:
//   state, opcode, alu_bcond, mem_ready -> ctrl (packed control word; unlisted fields are 0)
module mcfsm_output_decode
  import multicycle_control_fsm_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StIf: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
      end
      StId: begin
        // ALUOut <= PC + imm (branch/jump target precompute)
        ctrl.alu_src_b = SrcBImm;
      end
      StEx: begin
        case (opcode)
          OpcOp: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_op    = AluFunct;
          end
          OpcOpImm: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
            ctrl.alu_op    = AluFunct;
          end
          OpcLoad, OpcStore, OpcJalr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBImm;
          end
          OpcBranch: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SrcBReg;
            ctrl.alu_op    = AluBranch;
            ctrl.pc_write  = alu_bcond;
            ctrl.pc_source = alu_bcond;
          end
          OpcJal: begin
            // rd <= PC+4 from the live ALU while PC <= ALUOut (target from ID)
            ctrl.alu_src_b = SrcBFour;
            ctrl.reg_write = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
          end
          default: begin
            // Non-halting ECALL or unknown opcode: just step to PC+4
            ctrl.alu_src_b = SrcBFour;
            ctrl.pc_write  = 1'b1;
          end
        endcase
      end
      StMem: begin
        ctrl.i_or_d = 1'b1;
        if (opcode == OpcStore) begin
          ctrl.mem_write = 1'b1;
          if (mem_ready) begin
            ctrl.alu_src_b = SrcBFour;
            ctrl.pc_write  = 1'b1;
          end
        end else begin
          ctrl.mem_read = 1'b1;
        end
      end
      StWb: begin
        // rd takes ALUOut (R/I, mem_to_reg=0), MDR (load) or the live PC+4 (JALR)
        ctrl.alu_src_b  = SrcBFour;
        ctrl.reg_write  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.mem_to_reg = (opcode == OpcLoad);
        ctrl.pc_source  = (opcode == OpcJalr);
      end
      StBrNt: begin
        ctrl.alu_src_b = SrcBFour;
        ctrl.pc_write  = 1'b1;
      end
      StHalt: begin
        ctrl = '0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multi-cycle RV32I core. Sequences IF/ID/EX/MEM/WB over a shared ALU and
// unified memory, stops on the halting ECALL and keeps cycle / retired-instruction counters.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset (state IF, counters cleared, strobes forced low)
//   bus    - master side of multicycle_control_fsm_if (datapath inputs, control outputs,
//            is_halted, cycle_count, instret)
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HAS_READY = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             mem_ready_eff;
  logic [CNT_W-1:0] cycle_q, instret_q;

  assign mem_ready_eff = MEM_HAS_READY ? bus.mem_ready : 1'b1;

  mcfsm_output_decode u_output_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .alu_bcond (bus.alu_bcond),
    .mem_ready (mem_ready_eff),
    .ctrl      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIf: if (mem_ready_eff) state_d = StId;
      StId: begin
        if (bus.opcode == OpcSystem && bus.ecall_halt) state_d = StHalt;
        else                                           state_d = StEx;
      end
      StEx: begin
        case (bus.opcode)
          OpcOp, OpcOpImm, OpcJalr: state_d = StWb;
          OpcLoad, OpcStore:        state_d = StMem;
          OpcBranch:                state_d = bus.alu_bcond ? StIf : StBrNt;
          default:                  state_d = StIf;
        endcase
      end
      StMem: if (mem_ready_eff) state_d = (bus.opcode == OpcLoad) ? StWb : StIf;
      StWb, StBrNt: state_d = StIf;
      StHalt:       state_d = StHalt;
      default:      state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIf;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != StHalt) cycle_q <= cycle_q + CNT_W'(1);
      if (ctrl.pc_write)     instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Strobes are masked during reset so an interrupted access or write never completes.
  always_comb begin
    bus.pc_write    = ctrl.pc_write & ~reset;
    bus.mem_read    = ctrl.mem_read & ~reset;
    bus.mem_write   = ctrl.mem_write & ~reset;
    bus.ir_write    = ctrl.ir_write & ~reset;
    bus.reg_write   = ctrl.reg_write & ~reset;
    bus.pc_source   = ctrl.pc_source;
    bus.i_or_d      = ctrl.i_or_d;
    bus.alu_src_a   = ctrl.alu_src_a;
    bus.alu_src_b   = ctrl.alu_src_b;
    bus.alu_op      = ctrl.alu_op;
    bus.mem_to_reg  = ctrl.mem_to_reg;
    // HALT self-loops until reset, so the flag is sticky
    bus.is_halted   = (state_q == StHalt);
    bus.cycle_count = cycle_q;
    bus.instret     = instret_q;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-stream bench for multicycle_control_fsm. For each instruction the
// bench expands the per-instruction cycle recipe (fetch waits, decode, execute, memory waits,
// write-back) into an expected control word per cycle and tracks the expected counters.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int KR = 0, KI = 1, KLd = 2, KSt = 3, KBt = 4, KBn = 5;
  localparam int KJal = 6, KJalr = 7, KEc = 8, KUnk = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  longint unsigned cyc_exp = 0, ret_exp = 0;
  logic [6:0] pend_opcode = 7'd0;
  logic       pend_bcond = 1'b0, pend_ecall = 1'b0;

  multicycle_control_fsm_if #(.CNT_W(32)) bus ();

  multicycle_control_fsm #(.CNT_W(32), .MEM_HAS_READY(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Argument order: pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a,
  // alu_src_b, alu_op, reg_write, mem_to_reg
  function automatic ctrl_t mk(input logic pcw, pcs, iod, mr, mw, irw, a,
                               input logic [1:0] b, op, input logic rw, m2r);
    ctrl_t c;
    c.pc_write = pcw;  c.pc_source = pcs; c.i_or_d = iod;   c.mem_read = mr;
    c.mem_write = mw;  c.ir_write = irw;  c.alu_src_a = a;  c.alu_src_b = b;
    c.alu_op = op;     c.reg_write = rw;  c.mem_to_reg = m2r;
    return c;
  endfunction

  function automatic ctrl_t obs();
    return mk(bus.pc_write, bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
              bus.mem_to_reg);
  endfunction

  // One clock cycle: apply inputs just after the edge, check just before the next one.
  task automatic step(input ctrl_t exp, input logic rdy, input logic halt_exp);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus.mem_ready  = rdy;
    bus.opcode     = pend_opcode;
    bus.alu_bcond  = pend_bcond;
    bus.ecall_halt = pend_ecall;
    @(negedge clk);
    check_eq("ctrl_word", 64'(obs()), 64'(exp));
    check_eq("is_halted", 64'(bus.is_halted), 64'(halt_exp));
    check_eq("cycle_count", 64'(bus.cycle_count), cyc_exp);
    check_eq("instret", 64'(bus.instret), ret_exp);
    if (!halt_exp) cyc_exp = cyc_exp + 1;
    if (exp.pc_write) ret_exp = ret_exp + 1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'($urandom);
    @(negedge clk);
    check_eq("reset_strobes", 64'({bus.pc_write, bus.mem_read, bus.mem_write, bus.ir_write,
                                    bus.reg_write}), 64'd0);
    cyc_exp = 0;
    ret_exp = 0;
  endtask

  task automatic run_instr(input int kind, input int fw, input int mw, input bit abort_mem);
    ctrl_t pc4;
    pc4 = mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0);
    case (kind)
      KR:      pend_opcode = OpcOp;
      KI:      pend_opcode = OpcOpImm;
      KLd:     pend_opcode = OpcLoad;
      KSt:     pend_opcode = OpcStore;
      KBt,
      KBn:     pend_opcode = OpcBranch;
      KJal:    pend_opcode = OpcJal;
      KJalr:   pend_opcode = OpcJalr;
      KEc:     pend_opcode = OpcSystem;
      default: pend_opcode = 7'b0110111;
    endcase
    pend_bcond = (kind == KBt) ? 1'b1 : (kind == KBn) ? 1'b0 : 1'($urandom);
    pend_ecall = (kind == KEc) ? 1'b0 : 1'($urandom);

    for (int i = 0; i < fw; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), 1'b0, 1'b0);
    step(mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0), 1'b1, 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0), 1'($urandom), 1'b0);

    case (kind)
      KR: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0, 0), 1'($urandom), 1'b0);
        step(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0), 1'($urandom), 1'b0);
      end
      KI: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 0, 0), 1'($urandom), 1'b0);
        step(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0), 1'($urandom), 1'b0);
      end
      KLd: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0), 1'($urandom), 1'b0);
        for (int i = 0; i < mw; i++) step(mk(0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), 1'b0, 1'b0);
        step(mk(0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), 1'b1, 1'b0);
        step(mk(1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 1), 1'($urandom), 1'b0);
      end
      KSt: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0), 1'($urandom), 1'b0);
        for (int i = 0; i < mw; i++) step(mk(0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0), 1'b0, 1'b0);
        if (abort_mem) do_reset();
        else step(mk(1, 0, 1, 0, 1, 0, 0, 2'd1, 2'd0, 0, 0), 1'b1, 1'b0);
      end
      KBt: step(mk(1, 1, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0), 1'($urandom), 1'b0);
      KBn: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0, 0), 1'($urandom), 1'b0);
        step(pc4, 1'($urandom), 1'b0);
      end
      KJal: step(mk(1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0), 1'($urandom), 1'b0);
      KJalr: begin
        step(mk(0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0), 1'($urandom), 1'b0);
        step(mk(1, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0), 1'($urandom), 1'b0);
      end
      default: step(pc4, 1'($urandom), 1'b0);
    endcase
  endtask

  initial begin
    bus.opcode     = 7'd0;
    bus.alu_bcond  = 1'b0;
    bus.ecall_halt = 1'b0;
    bus.mem_ready  = 1'b0;

    do_reset();
    // Directed cases first
    run_instr(KI, 0, 0, 1'b0);    // ADDI: IF ID EX WB
    run_instr(KLd, 0, 3, 1'b0);   // LW with 3 wait cycles in MEM
    run_instr(KBt, 0, 0, 1'b0);
    run_instr(KBn, 0, 0, 1'b0);
    run_instr(KJal, 0, 0, 1'b0);
    run_instr(KJalr, 0, 0, 1'b0);
    run_instr(KSt, 2, 2, 1'b0);
    run_instr(KEc, 1, 0, 1'b0);
    run_instr(KUnk, 0, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      run_instr(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b0);
    end

    // Halting ECALL right after reset: counters freeze at 2 cycles, 0 retired
    do_reset();
    pend_opcode = OpcSystem;
    pend_bcond  = 1'b0;
    pend_ecall  = 1'b1;
    step(mk(0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0), 1'b1, 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0), 1'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step('0, 1'($urandom), 1'b1);

    // Reset out of HALT, then reset in the middle of a STORE memory wait
    do_reset();
    run_instr(KSt, 0, 2, 1'b1);
    run_instr(KR, 0, 0, 1'b0);
    run_instr(KLd, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
